// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared state encoding, default sizes and peak record for the spectrum arbiter
package spectrum_pkg;
  localparam int N_BINS_D = 512;
  localparam int ADDR_W_D = 9;
  localparam int DATA_W_D = 16;
  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_PUBLISH} state_t;
  typedef struct packed {
    logic [DATA_W_D-1:0] mag;
    logic [ADDR_W_D-1:0] index;
  } peak_t;
endpackage

// File: rtl/spectrum_ram.sv
// spectrum_ram: single-port synchronous RAM, one-cycle read, no reset
module spectrum_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/spectrum_arbiter.sv
// spectrum_arbiter: shares the spectrum RAM between the FFT writer and display reader, tracks per-frame peak
module spectrum_arbiter
  import spectrum_pkg::*;
#(
  parameter int N_BINS  = N_BINS_D,
  parameter int ADDR_W  = ADDR_W_D,
  parameter int DATA_W  = DATA_W_D,
  parameter int SKIP_DC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_index,
  input  logic [DATA_W-1:0] wr_mag,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_index,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] peak_mag,
  output logic [ADDR_W-1:0] peak_index,
  output logic              frame_done,
  output logic              busy,
  output logic              wr_drop
);
  localparam int CW = ADDR_W + 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  peak_t run, run_base, run_n;
  logic accept, clr, upd;
  logic [DATA_W-1:0] rdata;

  spectrum_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (accept),
    .addr  (accept ? wr_index : rd_index),
    .wdata (wr_mag),
    .rdata (rdata)
  );

  // frame_start (or leaving S_PUBLISH) clears count and peak before this cycle's write is folded in
  always_comb begin
    accept   = wr_en && (state == S_FRAME || (state == S_IDLE && frame_start));
    clr      = frame_start || state == S_PUBLISH;
    cnt_n    = (clr ? '0 : cnt) + CW'(accept);
    run_base = clr ? '0 : run;
    upd      = accept && wr_mag > run_base.mag && !(SKIP_DC != 0 && wr_index == '0);
    run_n    = upd ? peak_t'{mag: wr_mag, index: wr_index} : run_base;
    state_n  = state == S_PUBLISH ? (frame_start ? S_FRAME : S_IDLE)
             : (state == S_FRAME || frame_start) ? (cnt_n == CW'(N_BINS) ? S_PUBLISH : S_FRAME)
             : S_IDLE;
  end

  // peak_* load on entry to S_PUBLISH so they change in the same cycle frame_done pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      run        <= '0;
      peak_mag   <= '0;
      peak_index <= '0;
      rd_valid   <= 1'b0;
      wr_drop    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      run      <= run_n;
      rd_valid <= rd_ack;
      wr_drop  <= wr_drop || (wr_en && !accept);
      if (state_n == S_PUBLISH) begin
        peak_mag   <= run_n.mag;
        peak_index <= run_n.index;
      end
    end
  end

  assign rd_ack     = rd_req && !accept;
  assign rd_data    = rd_valid ? rdata : '0;
  assign frame_done = state == S_PUBLISH;
  assign busy       = state != S_IDLE;
endmodule

// File: tb/tb_spectrum_arbiter.sv
// tb_spectrum_arbiter: directed scenarios plus random traffic checked every cycle against a frame-level model
module tb_spectrum_arbiter;
  logic clk = 1'b0;
  logic reset, frame_start, wr_en, rd_req;
  logic [8:0] wr_index, rd_index;
  logic [15:0] wr_mag;
  logic rd_ack, rd_valid, frame_done, busy, wr_drop;
  logic [15:0] rd_data, peak_mag;
  logic [8:0] peak_index;

  spectrum_arbiter dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .wr_en(wr_en),
    .wr_index(wr_index), .wr_mag(wr_mag), .rd_req(rd_req), .rd_index(rd_index),
    .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data), .peak_mag(peak_mag),
    .peak_index(peak_index), .frame_done(frame_done), .busy(busy), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, done_cnt = 0;
  bit m_open, m_pend, m_drop, m_valid, m_rknown, last_ack;
  int m_cnt, m_bmag, m_bidx, m_pmag, m_pidx, m_rdata;
  int mem [512];
  bit known [512];

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one clock: compare outputs with the model, then advance the model by this cycle's inputs
  task automatic cycle();
    bit acc, ack;
    #1;
    acc = wr_en && !m_pend && (m_open || frame_start);
    ack = rd_req && !acc;
    if (!reset) begin
      chk("rd_ack", rd_ack, ack);
      chk("rd_valid", rd_valid, m_valid);
      if (!m_valid) chk("rd_data_idle", rd_data, 0);
      else if (m_rknown) chk("rd_data", rd_data, m_rdata);
      chk("frame_done", frame_done, m_pend);
      chk("busy", busy, m_open || m_pend);
      chk("peak_mag", peak_mag, m_pmag);
      chk("peak_index", peak_index, m_pidx);
      chk("wr_drop", wr_drop, m_drop);
      if (frame_done) done_cnt++;
    end
    last_ack = ack;
    if (reset) begin
      m_open = 0; m_pend = 0; m_drop = 0; m_valid = 0;
      m_cnt = 0; m_bmag = 0; m_bidx = 0; m_pmag = 0; m_pidx = 0;
    end else begin
      m_valid = ack;
      if (ack) begin
        m_rdata = mem[rd_index];
        m_rknown = known[rd_index];
      end
      if (m_pend) begin
        m_pend = 0; m_open = frame_start; m_cnt = 0; m_bmag = 0; m_bidx = 0;
      end else if (frame_start) begin
        m_open = 1; m_cnt = 0; m_bmag = 0; m_bidx = 0;
      end
      if (acc) begin
        mem[wr_index] = wr_mag;
        known[wr_index] = 1;
        m_cnt++;
        if (wr_index != 0 && int'(wr_mag) > m_bmag) begin
          m_bmag = wr_mag;
          m_bidx = wr_index;
        end
        if (m_cnt == 512) begin
          m_open = 0; m_pend = 1; m_pmag = m_bmag; m_pidx = m_bidx;
        end
      end else if (wr_en) m_drop = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit fs, bit we, int idx, int mag);
    frame_start = fs;
    wr_en = we;
    wr_index = idx[8:0];
    wr_mag = mag[15:0];
    cycle();
  endtask

  initial begin
    int d0;
    reset = 1; frame_start = 0; wr_en = 0; wr_index = 0; wr_mag = 0; rd_req = 0; rd_index = 0;
    cycle(); cycle();
    reset = 0;
    // full frame with a read of bin 100 held across the whole burst
    drive(1, 0, 0, 0);
    rd_req = 1; rd_index = 100;
    for (int i = 0; i < 512; i++) drive(0, 1, i, i == 100 ? 'hF000 : i);
    wr_en = 0;
    #1;
    chk("t1_done", frame_done, 1);
    chk("t1_peak_index", peak_index, 100);
    chk("t1_peak_mag", peak_mag, 'hF000);
    chk("t3_ack_after_burst", rd_ack, 1);
    cycle();
    rd_req = 0;
    #1;
    chk("t3_valid", rd_valid, 1);
    chk("t3_data", rd_data, 'hF000);
    chk("t1_busy_low", busy, 0);
    cycle();
    // idle back-to-back reads
    for (int k = 3; k <= 5; k++) begin
      rd_req = 1; rd_index = k[8:0];
      #1;
      chk("t4_ack", rd_ack, 1);
      cycle();
      #1;
      chk("t4_data", rd_data, k);
    end
    rd_req = 0;
    cycle();
    // DC bin excluded; tie keeps the first non-DC bin
    drive(1, 0, 0, 0);
    for (int i = 0; i < 512; i++) drive(0, 1, i, i == 0 ? 'hFFFF : 5);
    wr_en = 0;
    #1;
    chk("t2_peak_index", peak_index, 1);
    chk("t2_peak_mag", peak_mag, 5);
    cycle();
    // write while idle is dropped and RAM keeps its old value
    drive(0, 1, 7, 'hAAAA);
    wr_en = 0;
    #1;
    chk("t5_drop", wr_drop, 1);
    rd_req = 1; rd_index = 7;
    cycle();
    rd_req = 0;
    #1;
    chk("t5_data", rd_data, 5);
    cycle();
    // restart at write #200 yields exactly one frame_done
    d0 = done_cnt;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 199; i++) drive(0, 1, i, $urandom_range(0, 'hFFFF));
    drive(1, 1, 199, $urandom_range(0, 'hFFFF));
    for (int i = 1; i < 512; i++) drive(0, 1, i, $urandom_range(0, 'hFFFF));
    wr_en = 0;
    cycle(); cycle();
    chk("t6_one_done", done_cnt - d0, 1);
    // reset at write #300 aborts the frame silently
    drive(1, 0, 0, 0);
    for (int i = 0; i < 299; i++) drive(0, 1, i, $urandom_range(1, 'hFFFF));
    wr_en = 0; frame_start = 0; reset = 1;
    cycle();
    reset = 0;
    d0 = done_cnt;
    repeat (600) cycle();
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_peak_mag", peak_mag, 0);
    chk("t6_peak_index", peak_index, 0);
    chk("t6_busy", busy, 0);
    // random traffic
    for (int c = 0; c < 4000; c++) begin
      reset = $urandom_range(0, 2999) == 0;
      if (reset) begin
        frame_start = 0; wr_en = 0; rd_req = 0;
      end else begin
        frame_start = (m_open || m_pend) ? $urandom_range(0, 1999) == 0 : $urandom_range(0, 19) == 0;
        wr_en = $urandom_range(0, 3) != 0;
        wr_index = 9'($urandom_range(0, 511));
        wr_mag = 16'($urandom_range(0, 15));
        if (!rd_req || last_ack) begin
          rd_req = $urandom_range(0, 2) == 0;
          rd_index = 9'($urandom_range(0, 511));
        end
      end
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spectrum_arbiter.md
Name: spectrum_arbiter

Overview:
Owns the single-port spectrum RAM that holds the FFT magnitude bins. It shares that RAM between two requesters: the FFT output stream, which writes and cannot stall, and the display reader, which uses a req/ack handshake and can be stalled. It also tracks the peak bin of each frame and publishes it with a one-cycle frame_done pulse. It sits between the FFT output stage (sequenced by the FFT control FSM) and the VGA spectrum/peak display.

Parameters:
N_BINS, 512, bins per frame (power of two)
ADDR_W, 9, bin index width, log2(N_BINS)
DATA_W, 16, magnitude width
SKIP_DC, 1, when 1, bin 0 is excluded from peak search

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
frame_start  in  1  pulse; opens a new frame and clears the running peak (driven by control's reset_max/fft_start sequencing)
wr_en  in  1  FFT output bin valid this cycle
wr_index  in  ADDR_W  bin index of wr_mag
wr_mag  in  DATA_W  bin magnitude
rd_req  in  1  display read request; held until rd_ack
rd_index  in  ADDR_W  bin to read; stable while rd_req is high
rd_ack  out  1  request accepted this cycle
rd_valid  out  1  rd_data valid (1 cycle after rd_ack)
rd_data  out  DATA_W  read magnitude
peak_mag  out  DATA_W  published peak magnitude of last complete frame
peak_index  out  ADDR_W  published peak bin
frame_done  out  1  one-cycle pulse when peak_* update
busy  out  1  high while in S_FRAME or S_PUBLISH
wr_drop  out  1  sticky; a write arrived outside S_FRAME; cleared only by reset

Behaviour:
- Reset values: every output is 0; state is S_IDLE; running peak and write count are 0. RAM contents are not cleared.
- FSM states: S_IDLE, S_FRAME, S_PUBLISH.
- S_IDLE:
  - frame_start -> S_FRAME, with count=0 and running peak=(0,0).
  - wr_en without frame_start -> write is dropped and wr_drop is set.
- frame_start with wr_en in the same cycle (S_IDLE or S_FRAME): the frame opens or restarts, and that write is accepted as write #1 (count becomes 1, peak is evaluated against the cleared value).
- S_FRAME:
  - Each wr_en writes RAM[wr_index] and increments count.
  - frame_start mid-frame restarts: count=0, peak cleared; RAM is not cleared.
  - The write that makes count==N_BINS moves the FSM to S_PUBLISH on the next cycle.
  - wr_index need not be sequential; the address is always wr_index.
- Peak update:
  - Update when wr_mag > running peak (strictly greater), so ties keep the earlier-written bin.
  - With SKIP_DC=1, wr_index==0 never updates the peak.
  - Unsigned compare.
- S_PUBLISH (exactly 1 cycle):
  - peak_mag/peak_index <= running peak; frame_done=1.
  - Next state is S_FRAME if frame_start is asserted this cycle, else S_IDLE.
  - wr_en here is dropped and sets wr_drop.
- Arbitration (the RAM has one port, read latency 1):
  - Any write accepted in the current cycle owns the port.
  - rd_ack=1 iff rd_req && no write is accepted this cycle.
  - Dropped writes do not block reads.
  - rd_valid=1 and rd_data=RAM[rd_index] are presented the cycle after rd_ack.
  - At most one read is in flight; rd_req may be held across back-to-back acks (one read per cycle).
  - Worst-case read wait is N_BINS cycles (a full streamed frame).
- Read-during-frame: data is whatever the RAM holds (old or new); the display uses frame_done to qualify it.
- Reset mid-frame: the frame is aborted and published peak_* return to 0; no frame_done is generated.

Decomposition:
- spectrum_pkg holds:
  - the state enum {S_IDLE, S_FRAME, S_PUBLISH}
  - the N_BINS/ADDR_W/DATA_W defaults
  - a peak_t struct {mag, index}
- Sub-module spectrum_ram: single-port synchronous RAM with ports we, addr, wdata, rdata (1-cycle read, no reset); it infers M9K.

Test Plan:
- Reset, then frame_start, then 512 consecutive writes with mag=index except bin 100 = 0xF000 -> frame_done exactly one cycle after the 512th write; peak_index=100, peak_mag=0xF000; busy low afterwards.
- SKIP_DC=1 with bin 0 = 0xFFFF and all other bins = 5 -> peak_index=1, peak_mag=5 (tie keeps first non-DC bin).
- rd_req on index 100 held during a 512-cycle write burst -> rd_ack only on the first cycle after the burst; rd_valid the next cycle with rd_data=0xF000.
- Idle back-to-back reads of indices 3,4,5 -> rd_ack on 3 consecutive cycles; rd_data 3,4,5 each one cycle later.
- wr_en in S_IDLE without frame_start -> RAM unchanged (read back the old value) and wr_drop=1 until reset.
- frame_start at write #200, then 512 writes; separately, reset at write #300 -> the restart yields exactly one frame_done after 512 more writes; the reset yields no frame_done, peak_*=0, state S_IDLE.
